// File: rtl/load_align_unit.sv
// Load data path: 1-2 word reads, byte align, sign/zero extend, tagged response.
// Define LOAD_MISALIGN_SPLIT_EN for misaligned loads (incl. word-crossing).
module load_align_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [2:0]        REQ_FUNC3,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [TAG_W-1:0]  REQ_TAG,
  output logic              MEM_RD_EN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_RVALID,
  input  logic [XLEN-1:0]   MEM_RDATA,
  output logic              RESP_VALID,
  input  logic              RESP_READY,
  output logic [XLEN-1:0]   RESP_DATA,
  output logic [TAG_W-1:0]  RESP_TAG,
  output logic              RESP_FAULT
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int LW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE, RD0, RD1, RESP
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          func3_q, func3_d;
  logic [OW-1:0]       off_q, off_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic                fault_q, fault_d;
`ifdef LOAD_MISALIGN_SPLIT_EN
  logic [XLEN-1:0]     beat0_q, beat0_d;
  logic                cross;
`endif

  logic                req_legal;
  logic                req_bad;
  logic [OW-1:0]       req_off;
  logic [2*XLEN-1:0]   wide;
  logic [XLEN-1:0]     sh;
  logic [XLEN-1:0]     res;
  logic [LW-1:0]       msb_idx;
  logic                sbit;
  int                  nbits;

  assign req_off = REQ_ADDR[OW-1:0];

  always_comb begin
    req_legal = 1'b0;
    unique case (1'b1)
      (REQ_FUNC3 == 3'b111): req_legal = 1'b0;
      (REQ_FUNC3 == 3'b011),
      (REQ_FUNC3 == 3'b110): req_legal = (XLEN == 64);
      default:               req_legal = 1'b1;
    endcase
  end

`ifdef LOAD_MISALIGN_SPLIT_EN
  assign req_bad = !req_legal;
  assign cross   = (int'(off_q) + (1 << func3_q[1:0])) > NB;
`else
  logic [OW-1:0] req_smask;
  logic          req_mis;
  assign req_smask = OW'((1 << REQ_FUNC3[1:0]) - 1);
  assign req_mis   = |(req_off & req_smask);
  assign req_bad   = !req_legal || req_mis;
`endif

  // beat1 is only live in RD1, so a one-beat load sees zeros above beat0
  always_comb begin
    wide = '0;
    wide[XLEN-1:0] = MEM_RDATA;
`ifdef LOAD_MISALIGN_SPLIT_EN
    if (state_q == RD1) wide = {MEM_RDATA, beat0_q};
`endif
    sh = XLEN'(wide >> {off_q, 3'b000});
    nbits = 8 << func3_q[1:0];
    if (nbits > XLEN) nbits = XLEN;
    msb_idx = LW'(nbits - 1);
    sbit = !func3_q[2] && sh[msb_idx];
    for (int i = 0; i < XLEN; i++)
      res[i] = (i < nbits) ? sh[i] : sbit;
  end

  always_comb begin
    state_d = state_q;
    func3_d = func3_q;
    off_d   = off_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    data_d  = data_q;
    fault_d = fault_q;
`ifdef LOAD_MISALIGN_SPLIT_EN
    beat0_d = beat0_q;
`endif
    unique case (state_q)
      IDLE: if (REQ_VALID) begin
        func3_d = REQ_FUNC3;
        off_d   = req_off;
        tag_d   = REQ_TAG;
        if (req_bad) begin
          fault_d = 1'b1;
          data_d  = '0;
          state_d = RESP;
        end else begin
          fault_d = 1'b0;
          addr_d  = REQ_ADDR & ~ADDR_W'(NB - 1);
          state_d = RD0;
        end
      end
      RD0: if (MEM_RVALID) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
        if (cross) begin
          beat0_d = MEM_RDATA;
          addr_d  = addr_q + ADDR_W'(NB);
          state_d = RD1;
        end else
`endif
        begin
          data_d  = res;
          state_d = RESP;
        end
      end
`ifdef LOAD_MISALIGN_SPLIT_EN
      RD1: if (MEM_RVALID) begin
        data_d  = res;
        state_d = RESP;
      end
`endif
      RESP: if (RESP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      func3_q <= '0;
      off_q   <= '0;
      tag_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
      beat0_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      func3_q <= func3_d;
      off_q   <= off_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fault_q <= fault_d;
`ifdef LOAD_MISALIGN_SPLIT_EN
      beat0_q <= beat0_d;
`endif
    end
  end

  assign REQ_READY  = (state_q == IDLE);
  assign MEM_RD_EN  = (state_q == RD0) || (state_q == RD1);
  assign MEM_ADDR   = addr_q;
  assign RESP_VALID = (state_q == RESP);
  assign RESP_DATA  = data_q;
  assign RESP_TAG   = tag_q;
  assign RESP_FAULT = fault_q;

endmodule
